// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB > LU > DBG with a bounded-wait LU override.
// The selected request is registered onto the rf_* outputs, so the register
// file sees at most one stable write per clock.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_reg,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_reg,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              lu_forced
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_LU = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rf_we_q;
    logic [ADDR_W-1:0]  rf_wr_reg_q;
    logic [DATA_W-1:0]  rf_wr_data_q;

    logic               grant;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    // Grant decision and starvation tracking; readies are held low during reset.
    always_comb begin
        wb_ready  = 1'b0;
        lu_ready  = 1'b0;
        dbg_ready = 1'b0;
        state_d   = NORMAL;
        cnt_d     = '0;
        if (reset_n) begin
            case (state_q)
                NORMAL: begin
                    if (wb_valid)       wb_ready  = 1'b1;
                    else if (lu_valid)  lu_ready  = 1'b1;
                    else if (dbg_valid) dbg_ready = 1'b1;
                    // LU is refused in NORMAL exactly when WB is also requesting.
                    if (lu_valid && wb_valid) begin
                        if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
                            state_d = FORCE_LU;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                FORCE_LU: begin
                    if (lu_valid)       lu_ready  = 1'b1;
                    else if (wb_valid)  wb_ready  = 1'b1;
                    else if (dbg_valid) dbg_ready = 1'b1;
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Mux the granted requester's address and data.
    always_comb begin
        grant    = wb_ready | lu_ready | dbg_ready;
        sel_reg  = '0;
        sel_data = '0;
        if (wb_ready) begin
            sel_reg  = wb_reg;
            sel_data = wb_data;
        end else if (lu_ready) begin
            sel_reg  = lu_reg;
            sel_data = lu_data;
        end else if (dbg_ready) begin
            sel_reg  = dbg_reg;
            sel_data = dbg_data;
        end
    end

    // State, counter and registered write port; r0 writes are consumed but suppressed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= NORMAL;
            cnt_q        <= '0;
            rf_we_q      <= 1'b0;
            rf_wr_reg_q  <= '0;
            rf_wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rf_we_q <= grant && (sel_reg != '0);
            if (grant) begin
                rf_wr_reg_q  <= sel_reg;
                rf_wr_data_q <= sel_data;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wr_reg  = rf_wr_reg_q;
    assign rf_wr_data = rf_wr_data_q;
    assign lu_forced  = (state_q == FORCE_LU);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: each driven cycle queues the
// expected register-file write, which is popped and compared one cycle later.
module tb_regfile_write_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clock;
    logic              reset_n;
    logic              wb_valid, lu_valid, dbg_valid;
    logic [ADDR_W-1:0] wb_reg, lu_reg, dbg_reg;
    logic [DATA_W-1:0] wb_data, lu_data, dbg_data;
    logic              wb_ready, lu_ready, dbg_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr_reg;
    logic [DATA_W-1:0] rf_wr_data;
    logic              lu_forced;

    regfile_write_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .lu_valid  (lu_valid),
        .lu_reg    (lu_reg),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .dbg_valid (dbg_valid),
        .dbg_reg   (dbg_reg),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .rf_we     (rf_we),
        .rf_wr_reg (rf_wr_reg),
        .rf_wr_data(rf_wr_data),
        .lu_forced (lu_forced)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic              we;
        logic              chk;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    logic [ADDR_W-1:0] hold_r;
    logic [DATA_W-1:0] hold_d;
    logic              hold_ok;
    int                k;

    // Single comparison point for every check in the bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected write-port contents after a granted transfer.
    task automatic push_grant(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        if (r == '0) begin
            sb.push_back({1'b0, 1'b0, r, d});
            hold_ok = 1'b0;
        end else begin
            sb.push_back({1'b1, 1'b1, r, d});
            hold_r  = r;
            hold_d  = d;
            hold_ok = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.sb_empty got=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rf_we"}, 32'(rf_we), 32'(e.we));
            if (e.chk) begin
                chk({tag, ".rf_wr_reg"}, 32'(rf_wr_reg), 32'(e.r));
                chk({tag, ".rf_wr_data"}, rf_wr_data, e.d);
            end
        end
    endtask

    // Drive one cycle, check readies and the previous slot's write, queue this slot's write.
    task automatic cycle(input string tag,
                         input logic wv, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                         input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ld,
                         input logic dv, input logic [ADDR_W-1:0] dr, input logic [DATA_W-1:0] dd,
                         input logic [2:0] exp_rdy, input logic exp_f);
        wb_valid = wv;  wb_reg = wr;  wb_data = wd;
        lu_valid = lv;  lu_reg = lr;  lu_data = ld;
        dbg_valid = dv; dbg_reg = dr; dbg_data = dd;
        @(negedge clock);
        chk({tag, ".wb_ready"},  32'(wb_ready),  32'(exp_rdy[2]));
        chk({tag, ".lu_ready"},  32'(lu_ready),  32'(exp_rdy[1]));
        chk({tag, ".dbg_ready"}, 32'(dbg_ready), 32'(exp_rdy[0]));
        chk({tag, ".lu_forced"}, 32'(lu_forced), 32'(exp_f));
        pop_check(tag);
        if (exp_rdy[2])      push_grant(wr, wd);
        else if (exp_rdy[1]) push_grant(lr, ld);
        else if (exp_rdy[0]) push_grant(dr, dd);
        else                 sb.push_back({1'b0, hold_ok, hold_r, hold_d});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 3'b000, 1'b0);
    endtask

    task automatic push_reset_state();
        sb.delete();
        sb.push_back({1'b0, 1'b1, ADDR_W'(0), DATA_W'(0)});
        hold_r  = '0;
        hold_d  = '0;
        hold_ok = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h55;
        lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
        dbg_valid = 1'b0; dbg_reg = '0; dbg_data = '0;
        hold_r = '0; hold_d = '0; hold_ok = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.rf_we",      32'(rf_we),      32'd0);
        chk("rst.rf_wr_reg",  32'(rf_wr_reg),  32'd0);
        chk("rst.rf_wr_data", rf_wr_data,      32'd0);
        chk("rst.lu_forced",  32'(lu_forced),  32'd0);
        chk("rst.wb_ready",   32'(wb_ready),   32'd0);
        wb_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        push_reset_state();

        // Single writes from each requester.
        cycle("wb1", 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);
        idle("wb1.after", 2);
        cycle("lu1", 1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD, 1'b0, '0, '0, 3'b010, 1'b0);
        idle("lu1.after", 2);
        cycle("dbg1", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 32'd1, 3'b001, 1'b0);
        idle("dbg1.after", 2);

        // Simultaneous requests: grant order WB, LU, DBG.
        cycle("sim0", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 3'b100, 1'b0);
        cycle("sim1", 1'b0, '0, '0,       1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 3'b010, 1'b0);
        cycle("sim2", 1'b0, '0, '0,       1'b0, '0, '0,       1'b1, 5'd6, 32'h66, 3'b001, 1'b0);
        idle("sim.after", 2);

        // Starvation override twice in a row; WB data changes only on acceptance.
        k = 0;
        for (int c = 0; c < 11; c++) begin
            cycle($sformatf("starve%0d", c),
                  1'b1, 5'd8, 32'h100 + 32'(k),
                  (c <= 9), (c < 5) ? 5'd10 : 5'd11, (c < 5) ? 32'hA5 : 32'h5A,
                  1'b0, '0, '0,
                  (c == 4 || c == 9) ? 3'b010 : 3'b100, (c == 4 || c == 9));
            if (!(c == 4 || c == 9)) k++;
        end
        idle("starve.after", 2);

        // Register 0 is consumed without a write strobe.
        cycle("r0",  1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);
        cycle("r1",  1'b1, 5'd1, 32'd2,         1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);
        idle("r1.after", 2);

        // Reset with LU counter at 3 and a WB write on the port.
        for (int c = 0; c < 3; c++)
            cycle($sformatf("pre%0d", c), 1'b1, 5'd12, 32'h120 + 32'(c),
                  1'b1, 5'd13, 32'h13, 1'b0, '0, '0, 3'b100, 1'b0);
        chk("mid.pending_we", 32'(rf_we), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid.rf_we",     32'(rf_we),     32'd0);
        chk("mid.rf_wr_reg", 32'(rf_wr_reg), 32'd0);
        chk("mid.wb_ready",  32'(wb_ready),  32'd0);
        chk("mid.lu_ready",  32'(lu_ready),  32'd0);
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        push_reset_state();
        for (int c = 0; c < 5; c++)
            cycle($sformatf("post%0d", c), 1'b1, 5'd14, 32'h140 + 32'(c),
                  1'b1, 5'd15, 32'h15, 1'b0, '0, '0,
                  (c == 4) ? 3'b010 : 3'b100, (c == 4));
        cycle("post5", 1'b1, 5'd14, 32'h144, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);

        // Long idle: no grants, write port holds its last address/data.
        idle("idle", 10);
        @(negedge clock);
        pop_check("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
